// File: rtl/bw_irf_pkg.sv
// Shared types and helpers for the IRF window controller: FSM states,
// window-address field extraction and the default register width.
package bw_irf_pkg;

   localparam int DW_DEFAULT = 72;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE_WR = 2'd1,
      RST_RD  = 2'd2,
      RST_WR  = 2'd3
   } state_t;

   // Window address layout: thread index in the top tw bits, slot below it.
   function automatic logic [31:0] thread_of(input logic [31:0] addr, input int tw, input int aw);
      return (addr >> (aw - tw)) & ((32'd1 << tw) - 32'd1);
   endfunction

   function automatic logic [31:0] slot_of(input logic [31:0] addr, input int tw, input int aw);
      return addr & ((32'd1 << (aw - tw)) - 32'd1);
   endfunction

endpackage

// File: rtl/bw_r_irf_nx1_mux.sv
// Parametrised N:1 word multiplexer over a flat bus; word k sits at [k*DW +: DW].
module bw_r_irf_nx1_mux
   import bw_irf_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = DW_DEFAULT,
   parameter int SW = $clog2(N)
) (
   input  logic [N*DW-1:0] din,
   input  logic [SW-1:0]   sel,
   output logic [DW-1:0]   dout
);

   logic [DW-1:0] leg [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_leg
         assign leg[gi] = din[gi*DW +: DW];
      end
   endgenerate

   assign dout = leg[sel];

endmodule

// File: rtl/bw_r_irf_window_ctl.sv
// Per-thread live registers with a save/restore window store, sequenced by
// a request/ready FSM that pulses op_done (and op_err on invalid restores).
module bw_r_irf_window_ctl
   import bw_irf_pkg::*;
#(
   parameter int DW    = DW_DEFAULT,
   parameter int NTHR  = 4,
   parameter int SLOTS = 8,
   parameter int TW    = $clog2(NTHR),
   parameter int AW    = $clog2(NTHR*SLOTS)
) (
   input  logic               clk,
   input  logic               rst_l,
   input  logic [NTHR-1:0]    wr_en,
   input  logic [NTHR*DW-1:0] wr_data,
   input  logic [TW-1:0]      rd_thread,
   output logic [DW-1:0]      rd_data,
   input  logic               save_req,
   input  logic [AW-1:0]      save_addr,
   input  logic               restore_req,
   input  logic [AW-1:0]      restore_addr,
   output logic               op_ready,
   output logic               op_done,
   output logic               op_err
);

   state_t                state_reg;
   logic [AW-1:0]         addr_reg;
   logic [DW-1:0]         snap_reg;
   logic [DW-1:0]         win_rd_reg;
   logic                  err_reg;
   logic                  op_ready_reg;
   logic                  op_done_reg;
   logic                  op_err_reg;
   logic [NTHR*SLOTS-1:0] valid_reg;
   logic [DW-1:0]         live_reg [NTHR];
   logic [DW-1:0]         window_mem [NTHR*SLOTS];

   logic [NTHR*DW-1:0]    live_flat;
   logic [TW-1:0]         save_thr;
   logic [TW-1:0]         addr_thr;
   logic [DW-1:0]         save_src;
   logic [DW-1:0]         restore_data;
   logic                  restore_commit;

   generate
      for (genvar gi = 0; gi < NTHR; gi++) begin : g_flat
         assign live_flat[gi*DW +: DW] = live_reg[gi];
      end
   endgenerate

   assign save_thr       = TW'(thread_of(32'(save_addr), TW, AW));
   assign addr_thr       = TW'(thread_of(32'(addr_reg), TW, AW));
   assign restore_commit = (state_reg == RST_WR);
   assign restore_data   = err_reg ? '0 : win_rd_reg;

   bw_r_irf_nx1_mux #(.N(NTHR), .DW(DW)) u_rd_mux (
      .din  (live_flat),
      .sel  (rd_thread),
      .dout (rd_data)
   );

   bw_r_irf_nx1_mux #(.N(NTHR), .DW(DW)) u_save_mux (
      .din  (live_flat),
      .sel  (save_thr),
      .dout (save_src)
   );

   // A restore commit wins over a same-thread write on the same edge.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int t = 0; t < NTHR; t++) live_reg[t] <= '0;
      end else begin
         for (int t = 0; t < NTHR; t++) begin
            if (restore_commit && addr_thr == TW'(t))
               live_reg[t] <= restore_data;
            else if (wr_en[t])
               live_reg[t] <= wr_data[t*DW +: DW];
         end
      end
   end

   // Window RAM: no reset, stale contents are masked by valid_reg.
   always_ff @(posedge clk) begin
      if (state_reg == SAVE_WR)
         window_mem[addr_reg] <= snap_reg;
      win_rd_reg <= window_mem[addr_reg];
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         snap_reg     <= '0;
         err_reg      <= 1'b0;
         op_ready_reg <= 1'b1;
         op_done_reg  <= 1'b0;
         op_err_reg   <= 1'b0;
         valid_reg    <= '0;
      end else begin
         op_done_reg <= 1'b0;
         op_err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (save_req) begin
                  addr_reg     <= save_addr;
                  snap_reg     <= save_src;
                  op_ready_reg <= 1'b0;
                  state_reg    <= SAVE_WR;
               end else if (restore_req) begin
                  addr_reg     <= restore_addr;
                  op_ready_reg <= 1'b0;
                  state_reg    <= RST_RD;
               end
            end
            SAVE_WR: begin
               valid_reg[addr_reg] <= 1'b1;
               op_done_reg         <= 1'b1;
               op_ready_reg        <= 1'b1;
               state_reg           <= IDLE;
            end
            RST_RD: begin
               err_reg   <= ~valid_reg[addr_reg];
               state_reg <= RST_WR;
            end
            RST_WR: begin
               op_done_reg  <= 1'b1;
               op_err_reg   <= err_reg;
               op_ready_reg <= 1'b1;
               state_reg    <= IDLE;
            end
            default: begin
               op_ready_reg <= 1'b1;
               state_reg    <= IDLE;
            end
         endcase
      end
   end

   assign op_ready = op_ready_reg;
   assign op_done  = op_done_reg;
   assign op_err   = op_err_reg;

endmodule
